bus_sequencer: RTL and testbench
================================

# bus_sequencer

Parametrised external-bus sequencer for micro-BESM, the successor to the fixed-step bus arbiter. Takes an opcode request from the microprogram sequencer and drives the busio register select/strobe signals and the memory strobes. It supports single read, single write, locked read-modify-write and block (burst) transfers. Memory wait states are handled through a ready handshake, and a stalled transfer is aborted by a bounded timeout.

## Interface
- BURST, 4: words per block transfer (BTRRD/BTRWR), 1..16
- TIMEOUT, 127: max consecutive not-ready cycles in a wait state before abort, ≥1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- request  in  1  one-cycle start pulse; opcode valid in same cycle
- opcode  in  4  operation: 9 DRD, 10 DWR, 11 RDMWR, 12 BTRWR, 13 BTRRD; others non-bus
- ready  in  1  memory acknowledge, sampled only in RD/WR states
- arx  out  2  busio register index: 0 ADDR, 1 CMD, 2 RDATA, 3 WDATA
- ecx  out  1  busio port enable
- wrx  out  1  busio write enable (latch bus into RDATA)
- astb  out  1  memory address strobe
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- lock  out  1  bus lock, high for whole RDMWR tenure
- widx  out  $clog2(BURST)+1  current word index within transfer
- done  out  1  idle/acknowledge level
- timeout  out  1  one-cycle pulse: transfer aborted on timeout
- badop  out  1  one-cycle pulse: request with unsupported nonzero opcode

## Operation
- All outputs registered or decoded from state only (Moore). No combinational path from inputs to outputs.
- Opcode latched on request. widx, wait counter and word counter are internal registers.
- State outputs ({arx,ecx,wrx,astb,rd,wr}):
  - IDLE {2,0,0,0,0,0}, done=1
  - ADDR {0,1,0,1,0,0}
  - RD {2,1,0,0,1,0}
  - LATCH {2,1,1,0,0,0}
  - WSET {3,1,0,0,0,0}
  - WR {3,1,0,0,0,1}
  - done=0 outside IDLE.
- Sequences:
  - DRD: ADDR→RD→LATCH→IDLE.
  - DWR: ADDR→WSET→WR→IDLE.
  - RDMWR: ADDR→RD→LATCH→WSET→WR→IDLE, with lock=1 from ADDR through WR. The address is not re-strobed.
  - BTRRD: ADDR, then BURST×(RD→LATCH), then IDLE. widx increments on leaving LATCH.
  - BTRWR: ADDR, then BURST×(WSET→WR), then IDLE. widx increments on leaving WR.
- RD/WR exit only when ready=1 is sampled. The state is held while ready=0.
- Wait counter clears on every entry to RD/WR and increments each cycle ready=0. If ready=0 while counter==TIMEOUT-1: go IDLE and pulse timeout. Remaining burst words are abandoned.
- widx clears on request and on entry to IDLE.
- Opcode 0 and opcodes 1–8, 14, 15: no bus cycle. The block stays/returns in IDLE. badop pulses for all of these except 0.
- Request in any non-IDLE state aborts the current transfer. The new opcode is latched and the block goes to ADDR (bus opcode) or IDLE (other). No done cycle is inserted.
- Request has priority over ready and timeout in the same cycle.
- Reset (any time, including mid-transfer): IDLE, outputs {2,0,0,0,0,0}, lock=0, widx=0, done=1, timeout=0, badop=0, counters 0.

## Timing
- Request sampled at edge N: ADDR during cycle N+1, done low from N+1.
- Zero-wait latency (ready=1 throughout), counted as cycles with done=0:
  - DRD 3, DWR 3, RDMWR 5
  - BTRRD/BTRWR 1+2·BURST
- Each ready=0 cycle in RD/WR adds one cycle.
- Timeout: the abort edge is the TIMEOUT-th consecutive not-ready cycle. IDLE and the timeout pulse occur in the following cycle.
- badop pulse appears in cycle N+1.
- astb is high exactly one cycle per transfer. rd/wr never high simultaneously. ecx=0 whenever done=1.

## Test plan
- DRD, ready tied 1: request+opcode 9 at edge 0 → ADDR (arx=0, astb=1) cycle 1; rd=1 cycle 2; wrx=1 cycle 3; done=1 cycle 4.
- DWR with ready low 3 cycles: wr held 4 cycles with arx=3; done after 1+1+4 cycles; timeout stays 0.
- BTRRD, BURST=4: exactly 4 LATCH cycles with widx 0,1,2,3; one astb pulse; done after 9 cycles.
- RDMWR: lock=1 from ADDR through WR; single astb; sequence rd→wrx→wr; done after 5 cycles.
- Timeout, TIMEOUT=4, ready stuck 0 in RD: 4 rd cycles, then timeout pulse and done=1 same cycle, widx=0. A fresh DRD then completes normally.
- Abort/reset: request opcode 10 during BTRWR word 2 → ADDR next cycle with widx=0. Reset asserted mid-WR → all outputs to reset values immediately, asynchronously. Opcode 5 → badop pulse, done stays 1.

Source files
------------

// File: rtl/bus_sequencer.sv
// ============================================================================
// bus_sequencer: external-bus sequencer driving busio select/strobe and memory
// strobes for single, locked RMW and burst transfers.  Rev 1.0
// ============================================================================
`default_nettype none

module bus_sequencer #(
  parameter int BURST   = 4,
  parameter int TIMEOUT = 127
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   request_i,
  input  logic [3:0]             opcode_i,
  input  logic                   ready_i,
  output logic [1:0]             arx_o,
  output logic                   ecx_o,
  output logic                   wrx_o,
  output logic                   astb_o,
  output logic                   rd_o,
  output logic                   wr_o,
  output logic                   lock_o,
  output logic [$clog2(BURST):0] widx_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic                   badop_o
);

  localparam int WIDX_W = $clog2(BURST) + 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_DRD   = 4'd9;
  localparam logic [3:0] OP_DWR   = 4'd10;
  localparam logic [3:0] OP_RDMWR = 4'd11;
  localparam logic [3:0] OP_BTRWR = 4'd12;
  localparam logic [3:0] OP_BTRRD = 4'd13;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(BURST - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_RD    = 3'd2,
    S_LATCH = 3'd3,
    S_WSET  = 3'd4,
    S_WR    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic                to_d, bad_d;
  logic [6:0]          strobes_d;
  logic                lock_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    widx_d  = widx_q;
    wcnt_d  = wcnt_q;
    to_d    = 1'b0;
    bad_d   = 1'b0;

    // A request preempts whatever is in flight, including a pending timeout.
    if (request_i) begin
      op_d   = opcode_i;
      widx_d = '0;
      if (opcode_i >= OP_DRD && opcode_i <= OP_BTRRD) begin
        state_d = S_ADDR;
      end else begin
        state_d = S_IDLE;
        bad_d   = (opcode_i != 4'd0);
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR: state_d = (op_q == OP_DWR || op_q == OP_BTRWR) ? S_WSET : S_RD;
        S_RD: begin
          if (ready_i) begin
            state_d = S_LATCH;
          end else if (wcnt_q == WAIT_LAST) begin
            state_d = S_IDLE;
            to_d    = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (op_q == OP_RDMWR) begin
            state_d = S_WSET;
          end else if (op_q == OP_BTRRD && widx_q != LAST_WORD) begin
            state_d = S_RD;
            widx_d  = widx_q + 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WSET: state_d = S_WR;
        S_WR: begin
          if (ready_i) begin
            if (op_q == OP_BTRWR && widx_q != LAST_WORD) begin
              state_d = S_WSET;
              widx_d  = widx_q + 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (wcnt_q == WAIT_LAST) begin
            state_d = S_IDLE;
            to_d    = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q || request_i) begin
      wcnt_d = '0;
    end
    if (state_d == S_IDLE) begin
      widx_d = '0;
    end
  end

  // Output decode works on the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    case (state_d)
      S_ADDR:  strobes_d = {2'd0, 5'b10100};
      S_RD:    strobes_d = {2'd2, 5'b10010};
      S_LATCH: strobes_d = {2'd2, 5'b11000};
      S_WSET:  strobes_d = {2'd3, 5'b10000};
      S_WR:    strobes_d = {2'd3, 5'b10001};
      default: strobes_d = {2'd2, 5'b00000};
    endcase
    lock_d = (state_d != S_IDLE) && (op_d == OP_RDMWR);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      arx_o     <= 2'd2;
      ecx_o     <= 1'b0;
      wrx_o     <= 1'b0;
      astb_o    <= 1'b0;
      rd_o      <= 1'b0;
      wr_o      <= 1'b0;
      lock_o    <= 1'b0;
      widx_o    <= '0;
      done_o    <= 1'b1;
      timeout_o <= 1'b0;
      badop_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      {arx_o, ecx_o, wrx_o, astb_o, rd_o, wr_o} <= strobes_d;
      lock_o    <= lock_d;
      widx_o    <= widx_d;
      done_o    <= (state_d == S_IDLE);
      timeout_o <= to_d;
      badop_o   <= bad_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ============================================================================
// tb_bus_sequencer: scoreboard bench for bus_sequencer (BURST=4, TIMEOUT=4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_sequencer;

  localparam int BURST   = 4;
  localparam int TIMEOUT = 4;

  localparam int S_IDLE  = 0;
  localparam int S_ADDR  = 1;
  localparam int S_RD    = 2;
  localparam int S_LATCH = 3;
  localparam int S_WSET  = 4;
  localparam int S_WR    = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       request = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       ready = 1'b1;
  logic [1:0] arx;
  logic       ecx, wrx, astb, rd, wr, lock, done, timeout, badop;
  logic [2:0] widx;

  bus_sequencer #(.BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset), .request_i(request), .opcode_i(opcode),
    .ready_i(ready), .arx_o(arx), .ecx_o(ecx), .wrx_o(wrx), .astb_o(astb),
    .rd_o(rd), .wr_o(wr), .lock_o(lock), .widx_o(widx), .done_o(done),
    .timeout_o(timeout), .badop_o(badop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int wi;
    bit rdy;
    bit lk;
    bit to;
    bit bad;
  } ent_t;

  ent_t           plan[$];
  logic [13:0]    exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;
  int             cyc = 0;
  int             wl;
  bit             dead;
  logic [13:0]    obs;

  assign obs = {arx, ecx, wrx, astb, rd, wr, lock, widx, done, timeout, badop};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] vec(input ent_t e);
    logic [6:0] b;
    case (e.st)
      S_ADDR:  b = {2'd0, 5'b10100};
      S_RD:    b = {2'd2, 5'b10010};
      S_LATCH: b = {2'd2, 5'b11000};
      S_WSET:  b = {2'd3, 5'b10000};
      S_WR:    b = {2'd3, 5'b10001};
      default: b = {2'd2, 5'b00000};
    endcase
    return {b, e.lk, 3'(e.wi), (e.st == S_IDLE), e.to, e.bad};
  endfunction

  task automatic add(input int st, input int wi, input bit rdy, input bit lk,
                     input bit to, input bit bad);
    ent_t e;
    e.st = st; e.wi = wi; e.rdy = rdy; e.lk = lk; e.to = to; e.bad = bad;
    plan.push_back(e);
  endtask

  // Non-sampled states get random ready to show it is ignored there.
  task automatic nw(input int st, input int wi, input bit lk);
    if (!dead) add(st, wi, 1'($urandom_range(0, 1)), lk, 1'b0, 1'b0);
  endtask

  task automatic wst(input int st, input int wi, input bit lk);
    if (dead) return;
    if (wl >= TIMEOUT) begin
      repeat (TIMEOUT) add(st, wi, 1'b0, lk, 1'b0, 1'b0);
      dead = 1'b1;
    end else begin
      repeat (wl) add(st, wi, 1'b0, lk, 1'b0, 1'b0);
      add(st, wi, 1'b1, lk, 1'b0, 1'b0);
      wl = 0;
    end
  endtask

  task automatic build(input int op, input int waits);
    bit lk;
    plan.delete();
    wl   = waits;
    dead = 1'b0;
    if (op < 9 || op > 13) begin
      add(S_IDLE, 0, 1'b1, 1'b0, 1'b0, op != 0);
      return;
    end
    lk = (op == 11);
    nw(S_ADDR, 0, lk);
    case (op)
      9:  begin wst(S_RD, 0, lk); nw(S_LATCH, 0, lk); end
      10: begin nw(S_WSET, 0, lk); wst(S_WR, 0, lk); end
      11: begin wst(S_RD, 0, lk); nw(S_LATCH, 0, lk); nw(S_WSET, 0, lk); wst(S_WR, 0, lk); end
      12: for (int w = 0; w < BURST; w++) begin nw(S_WSET, w, lk); wst(S_WR, w, lk); end
      default: for (int w = 0; w < BURST; w++) begin wst(S_RD, w, lk); nw(S_LATCH, w, lk); end
    endcase
    add(S_IDLE, 0, 1'b1, 1'b0, dead, 1'b0);
  endtask

  task automatic tick();
    logic [13:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (exp_q.size() == 0) begin
      check_value("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_value($sformatf("cyc%0d", cyc), 32'(obs), 32'(e));
    end
  endtask

  // keep >= 0 truncates the planned sequence so the next call aborts it.
  task automatic run(input int op, input int waits, input int keep, input bit rdy0);
    build(op, waits);
    if (keep >= 0) while (plan.size() > keep) void'(plan.pop_back());
    request = 1'b1;
    opcode  = 4'(op);
    ready   = rdy0;
    exp_q.push_back(vec(plan[0]));
    tick();
    request = 1'b0;
    opcode  = 4'($urandom_range(0, 15));
    for (int j = 0; j < plan.size() - 1; j++) begin
      ready = plan[j].rdy;
      exp_q.push_back(vec(plan[j + 1]));
      tick();
    end
  endtask

  task automatic idle(input int n);
    ent_t e;
    e.st = S_IDLE; e.wi = 0; e.rdy = 1'b0; e.lk = 1'b0; e.to = 1'b0; e.bad = 1'b0;
    repeat (n) begin
      request = 1'b0;
      ready   = 1'($urandom_range(0, 1));
      exp_q.push_back(vec(e));
      tick();
    end
  endtask

  initial begin
    ent_t rst_e;
    rst_e.st = S_IDLE; rst_e.wi = 0; rst_e.rdy = 1'b0; rst_e.lk = 1'b0;
    rst_e.to = 1'b0; rst_e.bad = 1'b0;

    repeat (3) @(negedge clk);
    check_value("reset_state", 32'(obs), 32'(vec(rst_e)));
    reset = 1'b0;
    idle(2);

    run(9, 0, -1, 1'b1);
    run(10, 3, -1, 1'b1);
    run(13, 0, -1, 1'b1);
    run(11, 0, -1, 1'b1);
    run(11, 2, -1, 1'b1);
    run(12, 1, -1, 1'b1);
    run(13, 2, -1, 1'b1);

    run(9, 10, -1, 1'b1);
    run(9, 0, -1, 1'b1);
    run(13, 5, -1, 1'b1);
    run(12, 7, -1, 1'b1);
    idle(1);

    run(12, 0, 6, 1'b1);
    run(10, 0, -1, 1'b1);

    run(9, 10, 5, 1'b1);
    run(10, 0, -1, 1'b0);

    run(11, 0, 3, 1'b1);
    run(0, 0, -1, 1'b1);
    run(11, 1, 4, 1'b1);
    run(7, 0, -1, 1'b1);
    idle(1);
    run(5, 0, -1, 1'b1);
    idle(1);
    run(14, 0, -1, 1'b1);
    run(0, 0, -1, 1'b1);
    idle(1);

    run(10, 3, 3, 1'b0);
    #1 reset = 1'b1;
    #1 check_value("reset_async", 32'(obs), 32'(vec(rst_e)));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_value("reset_hold", 32'(obs), 32'(vec(rst_e)));
    idle(1);
    run(9, 0, -1, 1'b1);
    run(12, 0, -1, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
